// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory line port between icache refill and dcache refill/writeback.
// One transaction in flight; a watchdog turns a missing memory response into an error completion.
module mem_arbiter #(
  parameter int LINE_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_rdy_o,
  output logic [LINE_W-1:0] ic_data_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_rdy_o,
  output logic [LINE_W-1:0] dc_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_rdy_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              err_o
);

  // state | meaning
  // IDLE  | arbitrate between ic_req_i / dc_req_i, latch winner into mem_* registers
  // BUSY  | mem_req_o high, waiting for mem_rdy_i or watchdog expiry
  // RESP  | one-cycle rdy pulse to the owner, requests not sampled
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ic_rdy_q, ic_rdy_d;
  logic              dc_rdy_q, dc_rdy_d;
  logic [LINE_W-1:0] ic_data_q, ic_data_d;
  logic [LINE_W-1:0] dc_data_q, dc_data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic              grant_dc;
  logic [LINE_W-1:0] ret_line;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    ic_rdy_d    = 1'b0;
    dc_rdy_d    = 1'b0;
    ic_data_d   = ic_data_q;
    dc_data_d   = dc_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    grant_dc    = dc_req_i && (!ic_req_i || rr_ptr_q);
    ret_line    = '0;

    case (state_q)
      S_IDLE: begin
        if (ic_req_i || dc_req_i) begin
          owner_d     = grant_dc;
          rr_ptr_d    = !grant_dc;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_dc && dc_we_i;
          mem_addr_d  = grant_dc ? dc_addr_i : ic_addr_i;
          mem_wdata_d = grant_dc ? dc_wdata_i : '0;
          // Watchdog counts down through TIMEOUT BUSY cycles; expiry is at zero.
          cnt_d       = CNT_W'(TIMEOUT - 1);
          state_d     = S_BUSY;
        end
      end

      S_BUSY: begin
        if (mem_rdy_i || (cnt_q == '0)) begin
          // A response arriving on the last watchdog cycle still counts as normal.
          if (mem_rdy_i) begin
            ret_line = mem_we_q ? '0 : mem_rdata_i;
          end else begin
            err_d = 1'b1;
          end
          if (owner_q) begin
            dc_data_d = ret_line;
            dc_rdy_d  = 1'b1;
          end else begin
            ic_data_d = ret_line;
            ic_rdy_d  = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      ic_rdy_q    <= 1'b0;
      dc_rdy_q    <= 1'b0;
      ic_data_q   <= '0;
      dc_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ic_rdy_q    <= ic_rdy_d;
      dc_rdy_q    <= dc_rdy_d;
      ic_data_q   <= ic_data_d;
      dc_data_q   <= dc_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign ic_rdy_o    = ic_rdy_q;
  assign ic_data_o   = ic_data_q;
  assign dc_rdy_o    = dc_rdy_q;
  assign dc_data_o   = dc_data_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized transactions against
// a transaction-level model (round-robin preference, latency budget, sticky error).
module tb_mem_arbiter;
  localparam int LINE_W  = 128;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              ic_req, dc_req, dc_we, mem_rdy;
  logic [ADDR_W-1:0] ic_addr, dc_addr;
  logic [LINE_W-1:0] dc_wdata, mem_rdata;
  logic              ic_rdy, dc_rdy, mem_req, mem_we, err;
  logic [LINE_W-1:0] ic_data, dc_data, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  int nchecks = 0;
  int nerr    = 0;
  int cyc_n   = 0;
  bit pref_m  = 1'b0;   // 0: icache wins a tie, 1: dcache wins a tie
  bit err_m   = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_rdy_o(ic_rdy), .ic_data_o(ic_data),
    .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
    .dc_rdy_o(dc_rdy), .dc_data_o(dc_data),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdy_i(mem_rdy), .mem_rdata_i(mem_rdata), .err_o(err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full transaction starting from an IDLE cycle with requests already driven.
  // drop: 0 keep requests, 1 drop owner's request, 2 drop both, applied when rdy is seen.
  task automatic do_txn(input int lat, input logic [LINE_W-1:0] rdata, input int drop,
                        input bit scramble, output bit own, output int rdy_cyc);
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wdata, exp_data;
    bit exp_we, tmo;
    int busy_n;
    own       = (ic_req && dc_req) ? pref_m : dc_req;
    pref_m    = !own;
    exp_addr  = own ? dc_addr : ic_addr;
    exp_we    = own && dc_we;
    exp_wdata = dc_wdata;
    tmo       = (lat > TIMEOUT - 1);
    busy_n    = tmo ? TIMEOUT : lat + 1;
    exp_data  = (tmo || exp_we) ? '0 : rdata;
    if (tmo) err_m = 1'b1;

    cyc();
    mem_rdy = 1'b0;
    for (int c = 1; c <= busy_n; c++) begin
      nchecks++;
      if ({mem_req, mem_we, ic_rdy, dc_rdy} !== {1'b1, exp_we, 2'b00}) begin
        nerr++;
        $display("FAIL busy_ctrl cyc%0d: req/we/ic_rdy/dc_rdy got %b want %b", c,
                 {mem_req, mem_we, ic_rdy, dc_rdy}, {1'b1, exp_we, 2'b00});
      end
      nchecks++;
      if (mem_addr !== exp_addr) begin
        nerr++;
        $display("FAIL busy_addr cyc%0d: got %h want %h", c, mem_addr, exp_addr);
      end
      if (exp_we) begin
        nchecks++;
        if (mem_wdata !== exp_wdata) begin
          nerr++;
          $display("FAIL busy_wdata cyc%0d: got %h want %h", c, mem_wdata, exp_wdata);
        end
      end
      if (scramble && c == 1) begin
        ic_addr  = $urandom;
        dc_addr  = $urandom;
        dc_wdata = rand_line();
        dc_we    = $urandom_range(0, 1);
      end
      if (!tmo && c == busy_n) begin
        mem_rdy   = 1'b1;
        mem_rdata = rdata;
      end
      cyc();
      mem_rdy = 1'b0;
    end

    rdy_cyc = cyc_n;
    nchecks++;
    if ({ic_rdy, dc_rdy} !== (own ? 2'b01 : 2'b10)) begin
      nerr++;
      $display("FAIL resp_rdy: ic/dc got %b want %b", {ic_rdy, dc_rdy}, (own ? 2'b01 : 2'b10));
    end
    nchecks++;
    if ((own ? dc_data : ic_data) !== exp_data) begin
      nerr++;
      $display("FAIL resp_data owner=%0d: got %h want %h", own, (own ? dc_data : ic_data), exp_data);
    end
    nchecks++;
    if ({mem_req, err} !== {1'b0, err_m}) begin
      nerr++;
      $display("FAIL resp_req_err: got %b want %b", {mem_req, err}, {1'b0, err_m});
    end
    if (drop == 2) begin
      ic_req = 1'b0;
      dc_req = 1'b0;
    end else if (drop == 1) begin
      if (own) dc_req = 1'b0;
      else     ic_req = 1'b0;
    end

    cyc();
    nchecks++;
    if ({ic_rdy, dc_rdy, mem_req, err} !== {3'b000, err_m}) begin
      nerr++;
      $display("FAIL idle_after: ic_rdy/dc_rdy/mem_req/err got %b want %b",
               {ic_rdy, dc_rdy, mem_req, err}, {3'b000, err_m});
    end
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_rdy = 1'b0;
    cyc();
    rst = 1'b0;
    pref_m = 1'b0;
    err_m  = 1'b0;
  endtask

  task automatic test_reset();
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
    hard_reset();
    cyc();
    nchecks++;
    if ({ic_rdy, dc_rdy, mem_req, mem_we, err} !== 5'b0 || mem_addr !== '0 ||
        ic_data !== '0 || dc_data !== '0 || mem_wdata !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: ctrl %b addr %h icd %h dcd %h wd %h want all zero",
               {ic_rdy, dc_rdy, mem_req, mem_we, err}, mem_addr, ic_data, dc_data, mem_wdata);
    end
  endtask

  task automatic test_ic_read();
    bit own; int r, s;
    ic_addr = 32'h100;
    ic_req  = 1'b1;
    s = cyc_n;
    do_txn(1, 128'h00408093_00308093_00208093_00108093, 1, 0, own, r);
    nchecks++;
    if (own !== 1'b0 || r - s !== 3) begin
      nerr++;
      $display("FAIL ic_read_latency: owner %0d cycle %0d want owner 0 cycle 3", own, r - s);
    end
  endtask

  task automatic test_dc_write();
    bit own; int r;
    dc_addr  = 32'h200;
    dc_wdata = {16{8'hA5}};
    dc_we    = 1'b1;
    dc_req   = 1'b1;
    do_txn(1, rand_line(), 1, 0, own, r);
    nchecks++;
    if (own !== 1'b1) begin
      nerr++;
      $display("FAIL dc_write_owner: got %0d want 1", own);
    end
    dc_we = 1'b0;
  endtask

  task automatic test_fairness();
    bit own; int r, last;
    hard_reset();
    ic_addr = 32'h1000; dc_addr = 32'h2000; dc_we = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      do_txn(1, rand_line(), (i == 3) ? 2 : 0, 0, own, r);
      nchecks++;
      if (own !== i[0]) begin
        nerr++;
        $display("FAIL fair_order txn%0d: owner %0d want %0d", i, own, i[0]);
      end
      if (i > 0) begin
        nchecks++;
        if (r - last !== 4) begin
          nerr++;
          $display("FAIL fair_spacing txn%0d: gap %0d want 4", i, r - last);
        end
      end
      last = r;
    end
  endtask

  task automatic test_timeout();
    bit own; int r;
    ic_addr = 32'h300; ic_req = 1'b1;
    do_txn(14, rand_line(), 1, 0, own, r);
    ic_req = 1'b1;
    do_txn(15, rand_line(), 1, 0, own, r);
    ic_req = 1'b1;
    do_txn(40, rand_line(), 1, 0, own, r);
    cyc();
    nchecks++;
    if (err !== 1'b1) begin
      nerr++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    dc_addr = 32'h340; dc_we = 1'b0; dc_req = 1'b1;
    do_txn(2, rand_line(), 1, 0, own, r);
  endtask

  task automatic test_reset_mid();
    ic_addr = 32'h400; ic_req = 1'b1;
    cyc();
    nchecks++;
    if (mem_req !== 1'b1) begin
      nerr++;
      $display("FAIL mid_busy: mem_req got %b want 1", mem_req);
    end
    rst = 1'b1; ic_req = 1'b0;
    cyc();
    rst = 1'b0; pref_m = 1'b0; err_m = 1'b0;
    nchecks++;
    if ({ic_rdy, dc_rdy, mem_req, mem_we, err} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        ic_data !== '0 || dc_data !== '0) begin
      nerr++;
      $display("FAIL mid_reset: ctrl %b addr %h want all zero",
               {ic_rdy, dc_rdy, mem_req, mem_we, err}, mem_addr);
    end
    mem_rdy = 1'b1; mem_rdata = rand_line();
    cyc();
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nchecks++;
      if ({ic_rdy, dc_rdy, mem_req, err} !== 4'b0 || ic_data !== '0) begin
        nerr++;
        $display("FAIL late_rdy cyc%0d: ctrl %b icd %h want zero", i, {ic_rdy, dc_rdy, mem_req, err}, ic_data);
      end
      cyc();
    end
  endtask

  task automatic test_idle_rdy();
    bit own; int r;
    mem_rdy = 1'b1; mem_rdata = rand_line();
    cyc();
    mem_rdy = 1'b0;
    nchecks++;
    if ({ic_rdy, dc_rdy, mem_req} !== 3'b0) begin
      nerr++;
      $display("FAIL idle_rdy: ctrl %b want 000", {ic_rdy, dc_rdy, mem_req});
    end
    ic_addr = 32'h500; ic_req = 1'b1;
    do_txn(1, rand_line(), 0, 0, own, r);
    do_txn(2, rand_line(), 1, 0, own, r);
    nchecks++;
    if (own !== 1'b0) begin
      nerr++;
      $display("FAIL held_req_owner: got %0d want 0", own);
    end
  endtask

  task automatic test_random();
    bit own; int r;
    for (int i = 0; i < 40; i++) begin
      ic_req = $urandom_range(0, 1);
      dc_req = $urandom_range(0, 1);
      if (!ic_req && !dc_req) dc_req = 1'b1;
      ic_addr  = $urandom;
      dc_addr  = $urandom;
      dc_we    = $urandom_range(0, 1);
      dc_wdata = rand_line();
      mem_rdy  = ($urandom_range(0, 3) == 0);
      mem_rdata = rand_line();
      do_txn($urandom_range(1, 18), rand_line(), $urandom_range(0, 2), 1, own, r);
    end
    ic_req = 1'b0; dc_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_ic_read();
    test_dc_write();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_idle_rdy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory line port between the instruction-cache refill path and the data-cache refill/writeback path.
- Two requesters go in; one memory-side request/ready handshake comes out.
- Grants are round-robin, one transaction at a time.
- A bounded-wait watchdog converts a hung memory response into an error completion so the core never deadlocks.

Parameters:
- LINE_W, 128, cache line width in bits (matches ICLLEN)
- ADDR_W, 32, byte address width
- TIMEOUT, 16, max BUSY cycles without mem_rdy before error completion (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ic_req  in  1  icache line read request, level, held until ic_rdy
- ic_addr  in  ADDR_W  icache line address, stable while ic_req
- ic_rdy  out  1  one-cycle completion pulse to icache
- ic_data  out  LINE_W  line returned, valid when ic_rdy
- dc_req  in  1  dcache request, level, held until dc_rdy
- dc_we  in  1  1 = line write, 0 = line read; stable while dc_req
- dc_addr  in  ADDR_W  dcache line address
- dc_wdata  in  LINE_W  write line
- dc_rdy  out  1  one-cycle completion pulse to dcache
- dc_data  out  LINE_W  read line, valid when dc_rdy (0 for writes)
- mem_req  out  1  request to memory (bus ldp)
- mem_we  out  1  write qualifier
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  LINE_W  latched write line
- mem_rdy  in  1  memory completion (bus ldr), one-cycle pulse
- mem_rdata  in  LINE_W  memory line (bus ldData), valid with mem_rdy
- err  out  1  sticky timeout flag

Behaviour:
- Single clock; reset is synchronous and active-high. rst overrides everything, including mid-transaction.
- On reset:
  - state=IDLE, rr_ptr=0 (icache preferred).
  - All outputs 0: ic_rdy, dc_rdy, mem_req, mem_we, err; data and address buses 0.
  - Timeout counter cleared.
  - Any in-flight memory response is dropped.
- FSM IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - Arbitrate. Only one req high → grant it.
  - Both high → grant icache if rr_ptr=0, else dcache.
  - On grant: latch owner, addr, we (icache forces we=0) and wdata into mem_* registers. Toggle rr_ptr to point at the non-granted requester. Go to BUSY.
  - No req → stay in IDLE.
- BUSY:
  - mem_req=1 and mem_* held stable. Timeout counter increments each cycle.
  - mem_rdy=1 → capture mem_rdata into the owner's data register (dcache write captures 0). Go to RESP. mem_req drops at that edge.
  - Counter reaches TIMEOUT-1 with no mem_rdy → set err (sticky), return data 0, go to RESP.
  - A mem_rdy in the same cycle as the timeout wins: normal completion, err not set.
- RESP:
  - Owner's rdy=1 for exactly one cycle; the other rdy stays 0. Then go to IDLE; counter cleared.
  - Requests are not sampled in RESP. Requesters drop req at the edge after seeing rdy.
  - A req still high in IDLE is treated as a new request.
- Latency with 1-cycle memory:
  - req sampled at edge 0 → mem_req cycle 1 → mem_rdy cycle 2 → rdy cycle 3.
  - Minimum 3 cycles; back-to-back throughput one line per 4 cycles.
- mem_rdy outside BUSY is ignored.
- Request changes while granted are ignored, since address and data are latched.
- Fairness: under continuous dual requests, grants strictly alternate I, D, I, D.

Test Plan:
- Reset then ic_req=1, ic_addr=0x100; memory returns 128'h00408093_00308093_00208093_00108093 one cycle after mem_req → ic_rdy=1 exactly in cycle 3 with that data; mem_addr=0x100, mem_we=0; dc_rdy stays 0.
- dc_req=1, dc_we=1, dc_addr=0x200, dc_wdata=128'hA5…A5 → mem_we=1, mem_wdata=A5…A5 during BUSY; dc_rdy pulses with dc_data=0.
- ic_req and dc_req both held high for 4 transactions after reset → grant order I, D, I, D; no rdy overlap; exactly 4 cycles between rdy pulses.
- mem_rdy never asserted, TIMEOUT=16 → after 16 BUSY cycles owner rdy=1, data=0, err=1 and err stays 1; the next request completes normally with err still 1.
- rst asserted in BUSY cycle 1 with mem_rdy arriving next cycle → outputs all 0 at the next edge; the late mem_rdy is ignored; no rdy pulse.
- mem_rdy pulse injected while IDLE, with ic_req held in RESP → no spurious rdy, and no duplicate grant in RESP.
